// File: rtl/rename_pkg.sv
// Shared sizing defaults and lane-slicing helper for the N-wide renamer.
package rename_pkg;
    localparam int NUM_A_REGS_DEF = 32;
    localparam int NUM_P_REGS_DEF = 64;
    localparam int AW_DEF         = $clog2(NUM_A_REGS_DEF);
    localparam int PW_DEF         = $clog2(NUM_P_REGS_DEF);
    localparam int FL_DEPTH_DEF   = NUM_P_REGS_DEF - NUM_A_REGS_DEF;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction
endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of physical registers: up to WIDTH pops and pushes per
// cycle, occupancy count, and a sticky flag for dropped (overflowing) pushes.
module free_list_fifo
    import rename_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int PW    = 6,
    parameter int DEPTH = 32,
    parameter int BASE  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PW:0]        pop_n_i,
    input  logic [WIDTH-1:0]   push_en_i,
    input  logic [WIDTH*PW-1:0] push_reg_i,
    output logic [WIDTH*PW-1:0] peek_o,
    output logic [PW:0]        count_o,
    output logic               err_o
);
    localparam int CW   = PW + 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PTRW-1:0] ptr_t;

    function automatic logic [DEPTH*PW-1:0] initial_fill();
        logic [DEPTH*PW-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) m[i*PW +: PW] = PW'(BASE + i);
        return m;
    endfunction

    localparam logic [DEPTH*PW-1:0] FL_RST = initial_fill();

    function automatic ptr_t wrap_add(input ptr_t p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return ptr_t'(s);
    endfunction

    logic [DEPTH*PW-1:0] mem_q, mem_d;
    ptr_t                head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d, push_cnt;
    logic                err_q, err_d;

    always_comb begin
        for (int k = 0; k < WIDTH; k++)
            peek_o[lane_lo(k, PW) +: PW] = mem_q[lane_lo(int'(wrap_add(head_q, k)), PW) +: PW];
    end

    // Room is judged after this cycle's pops; p-reg 0 is never returned.
    always_comb begin
        mem_d    = mem_q;
        push_cnt = '0;
        err_d    = err_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (push_en_i[k] && (push_reg_i[lane_lo(k, PW) +: PW] != '0)) begin
                if (int'(count_q) - int'(pop_n_i) + int'(push_cnt) < DEPTH) begin
                    mem_d[lane_lo(int'(wrap_add(tail_q, int'(push_cnt))), PW) +: PW] =
                        push_reg_i[lane_lo(k, PW) +: PW];
                    push_cnt = push_cnt + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        head_d  = wrap_add(head_q, int'(pop_n_i));
        tail_d  = wrap_add(tail_q, int'(push_cnt));
        count_d = count_q - pop_n_i + push_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q   <= FL_RST;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;
endmodule

// File: rtl/rename_unit_nw.sv
// N-wide rename stage: RAT with in-group dependency bypass, all-or-nothing
// allocation from the free list, registered per-lane results.
module rename_unit_nw
    import rename_pkg::*;
#(
    parameter  int NUM_A_REGS = NUM_A_REGS_DEF,
    parameter  int NUM_P_REGS = NUM_P_REGS_DEF,
    parameter  int WIDTH      = 2,
    localparam int AW         = $clog2(NUM_A_REGS),
    localparam int PW         = $clog2(NUM_P_REGS),
    localparam int FL_DEPTH   = NUM_P_REGS - NUM_A_REGS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [WIDTH-1:0]    in_valid_i,
    input  logic [WIDTH*AW-1:0] rd_i,
    input  logic [WIDTH*AW-1:0] rs1_i,
    input  logic [WIDTH*AW-1:0] rs2_i,
    output logic                ready_o,
    input  logic [WIDTH-1:0]    free_en_i,
    input  logic [WIDTH*PW-1:0] free_reg_i,
    output logic [WIDTH-1:0]    out_valid_o,
    output logic [WIDTH*PW-1:0] p_src1_o,
    output logic [WIDTH*PW-1:0] p_src2_o,
    output logic [WIDTH*PW-1:0] p_dest_o,
    output logic [WIDTH*PW-1:0] old_dest_o,
    output logic [PW:0]         free_count_o,
    output logic                err_o
);
    localparam int CW = PW + 1;

    function automatic logic [NUM_A_REGS*PW-1:0] identity_map();
        logic [NUM_A_REGS*PW-1:0] m;
        m = '0;
        for (int a = 0; a < NUM_A_REGS; a++) m[a*PW +: PW] = PW'(a);
        return m;
    endfunction

    localparam logic [NUM_A_REGS*PW-1:0] RAT_RST = identity_map();

    logic [NUM_A_REGS*PW-1:0] rat_q, rat_d;
    logic [WIDTH*PW-1:0]      peek, src1_q, src2_q, dest_q, old_q;
    logic [WIDTH-1:0]         alloc, out_valid_q;
    logic [CW-1:0]            need, pop_n, free_count;
    logic [PW-1:0]            src1_d [WIDTH];
    logic [PW-1:0]            src2_d [WIDTH];
    logic [PW-1:0]            dest_d [WIDTH];
    logic [PW-1:0]            old_d  [WIDTH];
    logic                     accept;

    // Lanes resolve in order; the youngest earlier lane writing a source wins.
    always_comb begin
        logic [AW-1:0] rd_k, rs1_k, rs2_k, rd_j;
        rd_k  = '0;
        rs1_k = '0;
        rs2_k = '0;
        rd_j  = '0;
        need  = '0;
        alloc = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rd_k      = rd_i[lane_lo(k, AW) +: AW];
            rs1_k     = rs1_i[lane_lo(k, AW) +: AW];
            rs2_k     = rs2_i[lane_lo(k, AW) +: AW];
            alloc[k]  = in_valid_i[k] && (rd_k != '0);
            dest_d[k] = alloc[k] ? peek[lane_lo(int'(need), PW) +: PW] : '0;
            src1_d[k] = (rs1_k == '0) ? '0 : rat_q[lane_lo(int'(rs1_k), PW) +: PW];
            src2_d[k] = (rs2_k == '0) ? '0 : rat_q[lane_lo(int'(rs2_k), PW) +: PW];
            old_d[k]  = (rd_k == '0) ? '0 : rat_q[lane_lo(int'(rd_k), PW) +: PW];
            for (int j = 0; j < k; j++) begin
                rd_j = rd_i[lane_lo(j, AW) +: AW];
                if (alloc[j]) begin
                    if (rd_j == rs1_k) src1_d[k] = dest_d[j];
                    if (rd_j == rs2_k) src2_d[k] = dest_d[j];
                    if (rd_j == rd_k)  old_d[k]  = dest_d[j];
                end
            end
            if (alloc[k]) need = need + CW'(1);
        end
    end

    assign ready_o = !rst_i && (free_count >= need);
    assign accept  = ready_o;
    assign pop_n   = accept ? need : '0;

    always_comb begin
        rat_d = rat_q;
        if (accept) begin
            for (int k = 0; k < WIDTH; k++)
                if (alloc[k])
                    rat_d[lane_lo(int'(rd_i[lane_lo(k, AW) +: AW]), PW) +: PW] = dest_d[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rat_q       <= RAT_RST;
            out_valid_q <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            old_q       <= '0;
        end else begin
            rat_q       <= rat_d;
            out_valid_q <= accept ? in_valid_i : '0;
            for (int k = 0; k < WIDTH; k++) begin
                src1_q[lane_lo(k, PW) +: PW] <= (accept && in_valid_i[k]) ? src1_d[k] : '0;
                src2_q[lane_lo(k, PW) +: PW] <= (accept && in_valid_i[k]) ? src2_d[k] : '0;
                dest_q[lane_lo(k, PW) +: PW] <= (accept && in_valid_i[k]) ? dest_d[k] : '0;
                old_q[lane_lo(k, PW) +: PW]  <= (accept && in_valid_i[k]) ? old_d[k]  : '0;
            end
        end
    end

    free_list_fifo #(
        .WIDTH (WIDTH),
        .PW    (PW),
        .DEPTH (FL_DEPTH),
        .BASE  (NUM_A_REGS)
    ) u_free_list (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pop_n_i    (pop_n),
        .push_en_i  (free_en_i),
        .push_reg_i (free_reg_i),
        .peek_o     (peek),
        .count_o    (free_count),
        .err_o      (err_o)
    );

    assign out_valid_o  = out_valid_q;
    assign p_src1_o     = src1_q;
    assign p_src2_o     = src2_q;
    assign p_dest_o     = dest_q;
    assign old_dest_o   = old_q;
    assign free_count_o = free_count;
endmodule

// File: tb/tb_rename_unit_nw.sv
// Bench for rename_unit_nw: queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rename_unit_nw;
    localparam int W     = 2;
    localparam int AW    = 5;
    localparam int PW    = 6;
    localparam int NA    = 32;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W-1:0]      in_valid = '0;
    logic [W*AW-1:0]   rd = '0, rs1 = '0, rs2 = '0;
    logic [W-1:0]      free_en = '0;
    logic [W*PW-1:0]   free_reg = '0;
    logic              ready, err;
    logic [W-1:0]      out_valid;
    logic [W*PW-1:0]   p_src1, p_src2, p_dest, old_dest;
    logic [PW:0]       free_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int fq[$];
    int m_rat[NA];
    bit m_err;
    bit e_valid[W];
    int e_src1[W], e_src2[W], e_dest[W], e_old[W];

    rename_unit_nw #(.NUM_A_REGS(32), .NUM_P_REGS(64), .WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .rd_i         (rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .ready_o      (ready),
        .free_en_i    (free_en),
        .free_reg_i   (free_reg),
        .out_valid_o  (out_valid),
        .p_src1_o     (p_src1),
        .p_src2_o     (p_src2),
        .p_dest_o     (p_dest),
        .old_dest_o   (old_dest),
        .free_count_o (free_count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_need();
        int n;
        n = 0;
        for (int k = 0; k < W; k++)
            if (in_valid[k] && rd[k*AW +: AW] != 0) n++;
        return n;
    endfunction

    // Model: rename lanes one at a time against a live map, then return frees.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            for (int p = NA; p < NA + DEPTH; p++) fq.push_back(p);
            for (int a = 0; a < NA; a++) m_rat[a] = a;
            m_err = 0;
            for (int k = 0; k < W; k++) begin
                e_valid[k] = 0; e_src1[k] = 0; e_src2[k] = 0; e_dest[k] = 0; e_old[k] = 0;
            end
        end else begin
            bit acc;
            acc = (fq.size() >= model_need());
            for (int k = 0; k < W; k++) begin
                int a_rd, a_s1, a_s2;
                a_rd = int'(rd[k*AW +: AW]);
                a_s1 = int'(rs1[k*AW +: AW]);
                a_s2 = int'(rs2[k*AW +: AW]);
                e_valid[k] = acc && in_valid[k];
                e_src1[k] = 0; e_src2[k] = 0; e_dest[k] = 0; e_old[k] = 0;
                if (e_valid[k]) begin
                    e_src1[k] = (a_s1 == 0) ? 0 : m_rat[a_s1];
                    e_src2[k] = (a_s2 == 0) ? 0 : m_rat[a_s2];
                    if (a_rd != 0) begin
                        e_old[k]    = m_rat[a_rd];
                        e_dest[k]   = fq.pop_front();
                        m_rat[a_rd] = e_dest[k];
                    end
                end
            end
            for (int k = 0; k < W; k++) begin
                if (free_en[k] && free_reg[k*PW +: PW] != 0) begin
                    if (fq.size() < DEPTH) fq.push_back(int'(free_reg[k*PW +: PW]));
                    else m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 32'(ready), 32'(fq.size() >= model_need()));
            for (int k = 0; k < W; k++) begin
                chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(e_valid[k]));
                chk($sformatf("p_src1[%0d]", k), 32'(p_src1[k*PW +: PW]), e_src1[k]);
                chk($sformatf("p_src2[%0d]", k), 32'(p_src2[k*PW +: PW]), e_src2[k]);
                chk($sformatf("p_dest[%0d]", k), 32'(p_dest[k*PW +: PW]), e_dest[k]);
                chk($sformatf("old_dest[%0d]", k), 32'(old_dest[k*PW +: PW]), e_old[k]);
            end
            chk("free_count", 32'(free_count), fq.size());
            chk("err", 32'(err), 32'(m_err));
        end
    end

    task automatic clear_inputs();
        in_valid = '0; rd = '0; rs1 = '0; rs2 = '0; free_en = '0; free_reg = '0;
    endtask

    task automatic set_lane(input int k, input bit v, input int a_rd, input int a_s1, input int a_s2);
        in_valid[k]       = v;
        rd[k*AW +: AW]    = AW'(a_rd);
        rs1[k*AW +: AW]   = AW'(a_s1);
        rs2[k*AW +: AW]   = AW'(a_s2);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Bypass within a group
        set_lane(0, 1, 5, 5, 0);
        set_lane(1, 1, 6, 5, 0);
        #1 chk("t1 ready", 32'(ready), 1);
        step();
        chk("t1 l0 src1", 32'(p_src1[0 +: PW]), 5);
        chk("t1 l0 dest", 32'(p_dest[0 +: PW]), 32);
        chk("t1 l0 old", 32'(old_dest[0 +: PW]), 5);
        chk("t1 l1 src1", 32'(p_src1[PW +: PW]), 32);
        chk("t1 l1 dest", 32'(p_dest[PW +: PW]), 33);
        chk("t1 l1 old", 32'(old_dest[PW +: PW]), 6);
        chk("t1 count", 32'(free_count), 30);

        // Same rd in both lanes
        do_reset();
        set_lane(0, 1, 7, 0, 0);
        set_lane(1, 1, 7, 0, 0);
        step();
        chk("t2 l0 dest", 32'(p_dest[0 +: PW]), 32);
        chk("t2 l0 old", 32'(old_dest[0 +: PW]), 7);
        chk("t2 l1 dest", 32'(p_dest[PW +: PW]), 33);
        chk("t2 l1 old", 32'(old_dest[PW +: PW]), 32);
        set_lane(0, 1, 0, 7, 7);
        step();
        chk("t2 read a7", 32'(p_src1[0 +: PW]), 33);
        chk("t2 read a7 src2", 32'(p_src2[0 +: PW]), 33);

        // x0 destination, lane1 idle
        do_reset();
        set_lane(0, 1, 0, 0, 0);
        step();
        chk("t3 out_valid", 32'(out_valid), 1);
        chk("t3 dest", 32'(p_dest[0 +: PW]), 0);
        chk("t3 src1", 32'(p_src1[0 +: PW]), 0);
        chk("t3 count", 32'(free_count), 32);

        // Exhaustion and wrap-around
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_lane(0, 1, 1, 0, 0);
            set_lane(1, 1, 2, 0, 0);
            step();
        end
        chk("t4 count empty", 32'(free_count), 0);
        set_lane(0, 1, 3, 1, 0);
        set_lane(1, 1, 4, 2, 0);
        #1 chk("t4 ready low", 32'(ready), 0);
        @(posedge clk);
        #2;
        chk("t4 stalled valid", 32'(out_valid), 0);
        free_en  = 2'b11;
        free_reg = {6'd6, 6'd5};
        @(posedge clk);
        #2;
        free_en = '0;
        free_reg = '0;
        chk("t4 count refilled", 32'(free_count), 2);
        #1 chk("t4 ready high", 32'(ready), 1);
        step();
        chk("t4 l0 dest", 32'(p_dest[0 +: PW]), 5);
        chk("t4 l1 dest", 32'(p_dest[PW +: PW]), 6);
        chk("t4 l0 src1", 32'(p_src1[0 +: PW]), 62);
        chk("t4 l1 src1", 32'(p_src1[PW +: PW]), 63);
        chk("t4 l0 old", 32'(old_dest[0 +: PW]), 3);

        // Overflow is sticky
        do_reset();
        free_en = 2'b01;
        free_reg = {6'd0, 6'd40};
        step();
        chk("t5 count", 32'(free_count), 32);
        chk("t5 err", 32'(err), 1);
        set_lane(0, 1, 8, 0, 0);
        step();
        chk("t5 err held", 32'(err), 1);
        chk("t5 count after alloc", 32'(free_count), 31);
        free_en = 2'b11;
        free_reg = {6'd0, 6'd41};
        step();
        chk("t5 count after free", 32'(free_count), 32);

        // Asynchronous reset between edges
        set_lane(0, 1, 10, 0, 0);
        step();
        #1 rst = 1'b1;
        #1;
        chk("t6 async valid", 32'(out_valid), 0);
        chk("t6 async dest", 32'(p_dest), 0);
        chk("t6 async count", 32'(free_count), 32);
        chk("t6 async err", 32'(err), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        set_lane(0, 1, 9, 0, 0);
        step();
        chk("t6 dest", 32'(p_dest[0 +: PW]), 32);
        chk("t6 old", 32'(old_dest[0 +: PW]), 9);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
